// File: rtl/pipe_isa_pkg.sv
// ISA constants for the 8-bit pipelined core: opcodes and instruction field slices.
package pipe_isa_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 3;
    localparam int RS_HI = 2;
    localparam int RS_LO = 0;

endpackage

// File: rtl/pipe_reg_file.sv
// NREG x DATA_W register file: two combinational read ports, a debug read port,
// one synchronous write port, asynchronous active-high reset.
module pipe_reg_file #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              We,
    input  logic [REG_AW-1:0] Waddr,
    input  logic [DATA_W-1:0] Wdata,
    input  logic [REG_AW-1:0] Raddr_a,
    output logic [DATA_W-1:0] Rdata_a,
    input  logic [REG_AW-1:0] Raddr_b,
    output logic [DATA_W-1:0] Rdata_b,
    input  logic [REG_AW-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data
);

    logic [DATA_W-1:0] regs_r [NREG];

    // Register storage; reset wins over any pending write on the same edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (We) begin
            regs_r[Waddr] <= Wdata;
        end
    end

    assign Rdata_a  = regs_r[Raddr_a];
    assign Rdata_b  = regs_r[Raddr_b];
    assign Dbg_Data = regs_r[Dbg_Addr];

endmodule

// File: rtl/id_ex_wb_stage.sv
// Decode, operand select, ALU, EX/WB register, flags and writeback of the 8-bit core.
// Optional EX/WB->ID operand forwarding is enabled by defining IDEX_FORWARD_EN.
module id_ex_wb_stage
    import pipe_isa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IF_ID_RegWrite,
    input  logic              IF_ID_ALUSrc,
    input  logic [7:0]        IF_ID_Instruction_Code,
    input  logic [DATA_W-1:0] IF_ID_Imm_Data,
    output logic              WB_RegWrite,
    output logic [REG_AW-1:0] WB_Rd,
    output logic [DATA_W-1:0] WB_Result,
    output logic              Zero_Flag,
    output logic              Carry_Flag,
    input  logic [REG_AW-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data
);

    logic [1:0]        op_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs_s;
    logic [DATA_W-1:0] rd_rf_s;
    logic [DATA_W-1:0] rs_rf_s;
    logic [DATA_W-1:0] rd_op_s;
    logic [DATA_W-1:0] rs_op_s;
    logic [DATA_W-1:0] src_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_carry_s;

    logic              wb_reg_write_r;
    logic [REG_AW-1:0] wb_rd_r;
    logic [DATA_W-1:0] wb_result_r;
    logic              zero_r;
    logic              carry_r;

    assign op_s = IF_ID_Instruction_Code[OP_HI:OP_LO];
    assign rd_s = IF_ID_Instruction_Code[RD_HI:RD_LO];
    assign rs_s = IF_ID_Instruction_Code[RS_HI:RS_LO];

    pipe_reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .Clk      (Clk),
        .Reset    (Reset),
        .We       (wb_reg_write_r),
        .Waddr    (wb_rd_r),
        .Wdata    (wb_result_r),
        .Raddr_a  (rd_s),
        .Rdata_a  (rd_rf_s),
        .Raddr_b  (rs_s),
        .Rdata_b  (rs_rf_s),
        .Dbg_Addr (Dbg_Addr),
        .Dbg_Data (Dbg_Data)
    );

`ifdef IDEX_FORWARD_EN
    // Operand forwarding from the EX/WB register when it targets a source register.
    always_comb begin
        rd_op_s = rd_rf_s;
        rs_op_s = rs_rf_s;
        if (wb_reg_write_r && (wb_rd_r == rd_s) && (op_s != OP_MOV)) begin
            rd_op_s = wb_result_r;
        end else begin
            rd_op_s = rd_rf_s;
        end
        if (wb_reg_write_r && (wb_rd_r == rs_s) && !IF_ID_ALUSrc) begin
            rs_op_s = wb_result_r;
        end else begin
            rs_op_s = rs_rf_s;
        end
    end
`else
    assign rd_op_s = rd_rf_s;
    assign rs_op_s = rs_rf_s;
`endif

    assign src_s  = IF_ID_ALUSrc ? IF_ID_Imm_Data : rs_op_s;
    assign sum_s  = {1'b0, rd_op_s} + {1'b0, src_s};
    assign diff_s = {1'b0, rd_op_s} - {1'b0, src_s};

    // ALU; the borrow of the widened subtraction equals rd < src (unsigned).
    always_comb begin
        alu_res_s   = src_s;
        alu_carry_s = 1'b0;
        case (op_s)
            OP_MOV: begin
                alu_res_s   = src_s;
                alu_carry_s = 1'b0;
            end
            OP_ADD: begin
                alu_res_s   = sum_s[DATA_W-1:0];
                alu_carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                alu_res_s   = diff_s[DATA_W-1:0];
                alu_carry_s = diff_s[DATA_W];
            end
            OP_AND: begin
                alu_res_s   = rd_op_s & src_s;
                alu_carry_s = 1'b0;
            end
            default: begin
                alu_res_s   = src_s;
                alu_carry_s = 1'b0;
            end
        endcase
    end

    // EX/WB register; rd and result are captured even for NOPs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wb_reg_write_r <= 1'b0;
            wb_rd_r        <= {REG_AW{1'b0}};
            wb_result_r    <= {DATA_W{1'b0}};
        end else begin
            wb_reg_write_r <= IF_ID_RegWrite;
            wb_rd_r        <= rd_s;
            wb_result_r    <= alu_res_s;
        end
    end

    // Flags register; only writing instructions update it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
        end else if (IF_ID_RegWrite) begin
            zero_r  <= (alu_res_s == {DATA_W{1'b0}});
            carry_r <= alu_carry_s;
        end
    end

    assign WB_RegWrite = wb_reg_write_r;
    assign WB_Rd       = wb_rd_r;
    assign WB_Result   = wb_result_r;
    assign Zero_Flag   = zero_r;
    assign Carry_Flag  = carry_r;

endmodule

// File: tb/tb_id_ex_wb_stage.sv
// Directed self-checking bench for id_ex_wb_stage (default build or IDEX_FORWARD_EN).
module tb_id_ex_wb_stage;
    import pipe_isa_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       IF_ID_RegWrite;
    logic       IF_ID_ALUSrc;
    logic [7:0] IF_ID_Instruction_Code;
    logic [7:0] IF_ID_Imm_Data;
    logic       WB_RegWrite;
    logic [2:0] WB_Rd;
    logic [7:0] WB_Result;
    logic       Zero_Flag;
    logic       Carry_Flag;
    logic [2:0] Dbg_Addr;
    logic [7:0] Dbg_Data;

    int n_assert = 0;
    int n_fail   = 0;

    id_ex_wb_stage dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .IF_ID_RegWrite         (IF_ID_RegWrite),
        .IF_ID_ALUSrc           (IF_ID_ALUSrc),
        .IF_ID_Instruction_Code (IF_ID_Instruction_Code),
        .IF_ID_Imm_Data         (IF_ID_Imm_Data),
        .WB_RegWrite            (WB_RegWrite),
        .WB_Rd                  (WB_Rd),
        .WB_Result              (WB_Result),
        .Zero_Flag              (Zero_Flag),
        .Carry_Flag             (Carry_Flag),
        .Dbg_Addr               (Dbg_Addr),
        .Dbg_Data               (Dbg_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one instruction, clock it in, and return 1 time unit after the edge.
    task automatic issue(input logic rw, input logic alusrc, input logic [1:0] op,
                         input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] imm);
        IF_ID_RegWrite         = rw;
        IF_ID_ALUSrc           = alusrc;
        IF_ID_Instruction_Code = {op, rd, rs};
        IF_ID_Imm_Data         = imm;
        @(posedge Clk);
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 1'b1, OP_MOV, 3'd0, 3'd0, 8'h00);
    endtask

    task automatic dbg(input string tag, input logic [2:0] addr, input logic [7:0] exp_v);
        Dbg_Addr = addr;
        #1;
        check(tag, {8'h00, Dbg_Data}, {8'h00, exp_v});
    endtask

    task automatic wb(input string tag, input logic rw, input logic [2:0] rd, input logic [7:0] res,
                      input logic z, input logic c);
        check({tag, "_rw"},  {15'h0, WB_RegWrite}, {15'h0, rw});
        check({tag, "_rd"},  {13'h0, WB_Rd},       {13'h0, rd});
        check({tag, "_res"}, {8'h0, WB_Result},    {8'h0, res});
        check({tag, "_z"},   {15'h0, Zero_Flag},   {15'h0, z});
        check({tag, "_c"},   {15'h0, Carry_Flag},  {15'h0, c});
    endtask

    initial begin
        Reset                  = 1'b1;
        IF_ID_RegWrite         = 1'b0;
        IF_ID_ALUSrc           = 1'b0;
        IF_ID_Instruction_Code = 8'h00;
        IF_ID_Imm_Data         = 8'h00;
        Dbg_Addr               = 3'd0;
        repeat (2) @(posedge Clk);
        #1;
        wb("rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        dbg("rst_r1", 3'd1, 8'h00);
        Reset = 1'b0;

        // 1. MOV R1,#0x05
        issue(1'b1, 1'b1, OP_MOV, 3'd1, 3'd0, 8'h05);
        wb("mov_r1", 1'b1, 3'd1, 8'h05, 1'b0, 1'b0);
        nop();
        dbg("mov_r1_rf", 3'd1, 8'h05);

        // 2. Back-to-back dependency on R5 (R5 is 0 before the MOV)
        issue(1'b1, 1'b1, OP_MOV, 3'd5, 3'd0, 8'h05);
        issue(1'b1, 1'b1, OP_ADD, 3'd5, 3'd0, 8'h03);
`ifdef IDEX_FORWARD_EN
        wb("fwd_add", 1'b1, 3'd5, 8'h08, 1'b0, 1'b0);
        nop();
        dbg("fwd_add_rf", 3'd5, 8'h08);
`else
        wb("stale_add", 1'b1, 3'd5, 8'h03, 1'b0, 1'b0);
        nop();
        dbg("stale_add_rf", 3'd5, 8'h03);
`endif

        // 3. R2=0xF0, ADD R2,#0x20 -> 0x10 with carry
        issue(1'b1, 1'b1, OP_MOV, 3'd2, 3'd0, 8'hF0);
        nop();
        issue(1'b1, 1'b1, OP_ADD, 3'd2, 3'd0, 8'h20);
        wb("add_carry", 1'b1, 3'd2, 8'h10, 1'b0, 1'b1);
        nop();
        dbg("add_carry_rf", 3'd2, 8'h10);

        // 4. R3=0x04, SUB #4 -> 0 (Z), then SUB #1 -> 0xFF (borrow)
        issue(1'b1, 1'b1, OP_MOV, 3'd3, 3'd0, 8'h04);
        nop();
        issue(1'b1, 1'b1, OP_SUB, 3'd3, 3'd0, 8'h04);
        wb("sub_zero", 1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
        nop();
        issue(1'b1, 1'b1, OP_SUB, 3'd3, 3'd0, 8'h01);
        wb("sub_borrow", 1'b1, 3'd3, 8'hFF, 1'b0, 1'b1);
        nop();
        dbg("sub_borrow_rf", 3'd3, 8'hFF);

        // 5. NOP with op=ADD rd=R1: result still captured, flags held (Z=0, C=1)
        issue(1'b0, 1'b1, OP_ADD, 3'd1, 3'd0, 8'h55);
        wb("nop", 1'b0, 3'd1, 8'h5A, 1'b0, 1'b1);
        nop();
        dbg("nop_r1", 3'd1, 8'h05);

        // AND clears carry; register-source ADD uses R2=0x10
        issue(1'b1, 1'b1, OP_MOV, 3'd6, 3'd0, 8'h3C);
        nop();
        issue(1'b1, 1'b1, OP_AND, 3'd6, 3'd0, 8'h0F);
        wb("and", 1'b1, 3'd6, 8'h0C, 1'b0, 1'b0);
        nop();
        issue(1'b1, 1'b0, OP_ADD, 3'd6, 3'd2, 8'hFF);
        wb("add_reg", 1'b1, 3'd6, 8'h1C, 1'b0, 1'b0);
        nop();
        dbg("add_reg_rf", 3'd6, 8'h1C);

        // 6. Reset in the cycle after MOV R4,#0x7E discards the write
        issue(1'b1, 1'b1, OP_MOV, 3'd4, 3'd0, 8'h7E);
        wb("pre_rst", 1'b1, 3'd4, 8'h7E, 1'b0, 1'b0);
        Reset = 1'b1;
        #1;
        wb("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        IF_ID_RegWrite = 1'b0;
        @(posedge Clk);
        #1;
        dbg("rst_r4", 3'd4, 8'h00);
        dbg("rst_r1_again", 3'd1, 8'h00);
        Reset = 1'b0;
        issue(1'b1, 1'b1, OP_MOV, 3'd4, 3'd0, 8'h11);
        wb("resume", 1'b1, 3'd4, 8'h11, 1'b0, 1'b0);
        nop();
        dbg("resume_r4", 3'd4, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
